// File: rtl/ram_arbiter_if.sv
// Signal bundle between ram_arbiter and its two requesters plus the shared RAM.
// slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_done;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  ram_rdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        output dbg_gnt, dbg_done, dbg_rdata,
        output ram_cs, ram_we, ram_addr, ram_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output ram_rdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        input  dbg_gnt, dbg_done, dbg_rdata,
        input  ram_cs, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (CPU / debug loader) arbiter for a single-ported 4K x 4 RAM, 3 cycles per access.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU always wins ties.
module ram_arbiter (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              cpu_gnt_q,   cpu_gnt_d;
    logic              dbg_gnt_q,   dbg_gnt_d;
    logic              cpu_done_q,  cpu_done_d;
    logic              dbg_done_q,  dbg_done_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              ram_cs_q,    ram_cs_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q,      busy_d;

    logic any_req_c;
    logic pick_dbg_c;

    assign any_req_c = bus.cpu_req | bus.dbg_req;

`ifdef RAM_ARB_RR_EN
    logic ptr_dbg_q, ptr_dbg_d;

    // Pointer names the port that wins a tie; it moves away from every winner.
    assign pick_dbg_c = bus.dbg_req & (~bus.cpu_req | ptr_dbg_q);

    always_comb begin
        ptr_dbg_d = ptr_dbg_q;
        if (state_q == IDLE && any_req_c) begin
            ptr_dbg_d = ~pick_dbg_c;
        end
    end
`else
    assign pick_dbg_c = bus.dbg_req & ~bus.cpu_req;
`endif

    // Next-state and next-output logic; ram_* carry the latched request only in ACCESS.
    always_comb begin
        state_d     = state_q;
        cpu_gnt_d   = cpu_gnt_q;
        dbg_gnt_d   = dbg_gnt_q;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    cpu_gnt_d   = ~pick_dbg_c;
                    dbg_gnt_d   = pick_dbg_c;
                    ram_cs_d    = 1'b1;
                    ram_we_d    = pick_dbg_c ? bus.dbg_we    : bus.cpu_we;
                    ram_addr_d  = pick_dbg_c ? bus.dbg_addr  : bus.cpu_addr;
                    ram_wdata_d = pick_dbg_c ? bus.dbg_wdata : bus.cpu_wdata;
                end
            end
            ACCESS: begin
                state_d    = DONE;
                cpu_done_d = cpu_gnt_q;
                dbg_done_d = dbg_gnt_q;
                if (!ram_we_q) begin
                    if (cpu_gnt_q) cpu_rdata_d = bus.ram_rdata;
                    if (dbg_gnt_q) dbg_rdata_d = bus.ram_rdata;
                end
            end
            DONE: begin
                state_d   = IDLE;
                cpu_gnt_d = 1'b0;
                dbg_gnt_d = 1'b0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                cpu_gnt_d = 1'b0;
                dbg_gnt_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef RAM_ARB_RR_EN
            ptr_dbg_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dbg_gnt_q   <= dbg_gnt_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
`ifdef RAM_ARB_RR_EN
            ptr_dbg_q   <= ptr_dbg_d;
`endif
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.dbg_gnt   = dbg_gnt_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dbg_done  = dbg_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed vector table, hand-written corner sequences,
// and random traffic against a transaction-level reference model.
module tb_ram_arbiter;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_arbiter_if bus();
    ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    // RAM model: contents reload to a known pattern while reset is high.
    logic [3:0] mem [4096];
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 4'(i);
        end else if (bus.ram_cs && bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    int checks   = 0;
    int failures = 0;

    function automatic logic [30:0] pack(input logic cg, input logic cd, input logic [3:0] cr,
                                         input logic dg, input logic dd, input logic [3:0] dr,
                                         input logic cs, input logic we, input logic [11:0] a,
                                         input logic [3:0] wd, input logic b);
        return {cg, cd, cr, dg, dd, dr, cs, we, a, wd, b};
    endfunction

    function automatic logic [30:0] dut_outs();
        return pack(bus.cpu_gnt, bus.cpu_done, bus.cpu_rdata, bus.dbg_gnt, bus.dbg_done,
                    bus.dbg_rdata, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.busy);
    endfunction

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cg cd crd dg dd drd cs we addr wd busy)",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [3:0] cd,
                         input logic dr, input logic dw, input logic [11:0] da, input logic [3:0] dd);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model (one outstanding transaction, scheduled by age) ----
    logic       m_active, m_win_dbg, m_we, m_last_dbg;
    int         m_age;
    logic [11:0] m_addr;
    logic [3:0] m_wdata, m_rd, m_cpu_rdata, m_dbg_rdata;
    logic [3:0] shadow [4096];

    task automatic model_reset();
        m_active = 1'b0; m_age = 0; m_win_dbg = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_rd = '0;
        m_cpu_rdata = '0; m_dbg_rdata = '0;
        m_last_dbg = 1'b1;  // so the CPU is first on a tie
        for (int i = 0; i < 4096; i++) shadow[i] = 4'(i);
    endtask

    task automatic model_step();
        if (m_active) begin
            m_age++;
            if (m_age == 1 && !m_we) begin
                if (m_win_dbg) m_dbg_rdata = m_rd;
                else           m_cpu_rdata = m_rd;
            end
            if (m_age == 3) m_active = 1'b0;
        end
        if (!m_active && (bus.cpu_req || bus.dbg_req)) begin
            if (bus.cpu_req && bus.dbg_req) m_win_dbg = RR ? !m_last_dbg : 1'b0;
            else                            m_win_dbg = bus.dbg_req;
            m_last_dbg = m_win_dbg;
            m_we    = m_win_dbg ? bus.dbg_we    : bus.cpu_we;
            m_addr  = m_win_dbg ? bus.dbg_addr  : bus.cpu_addr;
            m_wdata = m_win_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            if (m_we) shadow[m_addr] = m_wdata;
            else      m_rd = shadow[m_addr];
            m_active = 1'b1;
            m_age    = 0;
        end
    endtask

    function automatic logic [30:0] model_outs();
        logic owned, acc, dn;
        owned = m_active && m_age < 2;
        acc   = m_active && m_age == 0;
        dn    = m_active && m_age == 1;
        return pack(owned && !m_win_dbg, dn && !m_win_dbg, m_cpu_rdata,
                    owned && m_win_dbg, dn && m_win_dbg, m_dbg_rdata,
                    acc, acc && m_we, acc ? m_addr : 12'h0, acc ? m_wdata : 4'h0, owned);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        c_req; logic c_we; logic [11:0] c_addr; logic [3:0] c_wd;
        logic        d_req; logic d_we; logic [11:0] d_addr; logic [3:0] d_wd;
        int          win;   // 1 = CPU, 2 = debug
        logic [3:0]  exp_c; logic [3:0] exp_d;
    } vec_t;

    vec_t        vecs [8];
    vec_t        v;
    logic        w_c, w_d, e_we;
    logic [11:0] e_addr;
    logic [3:0]  e_wd, prev_c, prev_d;
    logic [23:0] trace, exp_trace;
    logic [1:0]  pair;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 12'h123, 4'hA, 1'b0, 1'b0, 12'h000, 4'h0, 1, 4'h0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 12'h123, 4'h7, 1'b0, 1'b0, 12'h000, 4'h0, 1, 4'hA, 4'h0};
        vecs[2] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b1, 12'hFFF, 4'h5, 2, 4'hA, 4'h0};
        vecs[3] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 12'hFFF, 4'h2, 2, 4'hA, 4'h5};
        vecs[4] = '{1'b1, 1'b0, 12'h456, 4'h3, 1'b1, 1'b1, 12'h456, 4'h9, 1, 4'h6, 4'h5};
        vecs[5] = '{1'b1, 1'b1, 12'h010, 4'hC, 1'b1, 1'b0, 12'h123, 4'h1,
                    RR ? 2 : 1, 4'h6, RR ? 4'hA : 4'h5};
        vecs[6] = '{1'b1, 1'b0, 12'h010, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0,
                    1, RR ? 4'h0 : 4'hC, RR ? 4'hA : 4'h5};
        vecs[7] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 12'h00E, 4'h4,
                    2, RR ? 4'h0 : 4'hC, 4'hE};

        reset = 1'b1;
        drive(0, 0, 12'h0, 4'h0, 0, 0, 12'h0, 4'h0);
        cycle();
        cycle();
        check("reset_state", dut_outs(), 31'h0);
        reset = 1'b0;

        prev_c = 4'h0;
        prev_d = 4'h0;
        for (int i = 0; i < 8; i++) begin
            v      = vecs[i];
            w_c    = (v.win == 1);
            w_d    = (v.win == 2);
            e_we   = w_d ? v.d_we   : v.c_we;
            e_addr = w_d ? v.d_addr : v.c_addr;
            e_wd   = w_d ? v.d_wd   : v.c_wd;
            drive(v.c_req, v.c_we, v.c_addr, v.c_wd, v.d_req, v.d_we, v.d_addr, v.d_wd);
            cycle();
            check($sformatf("vec%0d_access", i), dut_outs(),
                  pack(w_c, 1'b0, prev_c, w_d, 1'b0, prev_d, 1'b1, e_we, e_addr, e_wd, 1'b1));
            // odd rows drop the request mid-access; the access must still complete
            if (i % 2 == 1) begin bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; end
            cycle();
            check($sformatf("vec%0d_done", i), dut_outs(),
                  pack(w_c, w_c, v.exp_c, w_d, w_d, v.exp_d, 1'b0, 1'b0, 12'h0, 4'h0, 1'b1));
            bus.cpu_req = 1'b0;
            bus.dbg_req = 1'b0;
            cycle();
            check($sformatf("vec%0d_idle", i), dut_outs(),
                  pack(1'b0, 1'b0, v.exp_c, 1'b0, 1'b0, v.exp_d, 1'b0, 1'b0, 12'h0, 4'h0, 1'b0));
            prev_c = v.exp_c;
            prev_d = v.exp_d;
        end

        // Both ports hold req for 12 cycles: four back-to-back accesses, done every 3rd cycle.
        drive(1, 0, 12'h456, 4'h0, 1, 0, 12'h00E, 4'h0);
        trace     = '0;
        exp_trace = '0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            trace = {trace[21:0], bus.cpu_done, bus.dbg_done};
            if (k % 3 == 2) pair = (RR && (((k - 2) / 3) % 2 == 1)) ? 2'b01 : 2'b10;
            else            pair = 2'b00;
            exp_trace = {exp_trace[21:0], pair};
            check($sformatf("excl_c%0d", k), 31'({bus.cpu_gnt & bus.dbg_gnt, bus.cpu_done & bus.dbg_done}),
                  31'h0);
        end
        check("contention_trace", 31'(trace), 31'(exp_trace));
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        cycle();

        // Reset in the middle of an ACCESS cycle aborts the write without a done.
        drive(1, 1, 12'h321, 4'hF, 0, 0, 12'h0, 4'h0);
        cycle();
        check("pre_abort_access", dut_outs(),
              pack(1'b1, 1'b0, RR ? 4'h6 : 4'h6, 1'b0, 1'b0, 4'hE, 1'b1, 1'b1, 12'h321, 4'hF, 1'b1));
        reset = 1'b1;
        #1;
        check("abort_immediate", dut_outs(), 31'h0);
        bus.cpu_req = 1'b0;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("abort_no_done%0d", k), dut_outs(), 31'h0);
        end
        drive(1, 0, 12'h321, 4'h0, 0, 0, 12'h0, 4'h0);
        cycle();
        check("post_reset_access", dut_outs(),
              pack(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h321, 4'h0, 1'b1));
        bus.cpu_req = 1'b0;
        cycle();
        check("post_reset_done", dut_outs(),
              pack(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h0, 4'h0, 1'b1));
        cycle();

        // Random traffic against the reference model.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 900; n++) begin
            check($sformatf("random_c%0d", n), dut_outs(), model_outs());
            drive(($urandom % 3) != 0, 1'($urandom), ($urandom % 4 == 0) ? 12'($urandom) : 12'($urandom % 8),
                  4'($urandom),
                  ($urandom % 3) != 0, 1'($urandom), ($urandom % 4 == 0) ? 12'($urandom) : 12'($urandom % 8),
                  4'($urandom));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        check("random_final", dut_outs(), model_outs());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
